// File: rtl/nios_system_pio_pkg.sv
// Shared constants, bus request type and edge-detect helper for the Nios II PIO slaves.
package nios_system_pio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = ADDR_W'(3);

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } pio_req_t;

  // Per-bit edge event between two consecutive debounced samples.
  function automatic logic [DATA_W-1:0] edge_event(input int unsigned     edge_type,
                                                   input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] prev);
    case (edge_type)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      EDGE_ANY:  return cur ^ prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/nios_system_key_pio_in_if.sv
// Avalon-MM slave bus of the key input PIO, including its interrupt line.
interface nios_system_key_pio_in_if;
  import nios_system_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_system_pio_debounce.sv
// Two-flop synchronizer plus tick-sampled debounce; the first tick after reset only primes the history.
module nios_system_pio_debounce #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_prev,
  output logic             sample_valid
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             primed;

  assign tick = (cnt == CNT_LAST);

  // Metastability guard for the asynchronous key inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Free-running sample-interval counter, unaffected by bus traffic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Unprimed tick loads both samples identically so no edge can be seen across reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_in      <= '0;
      data_prev    <= '0;
      primed       <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (tick) begin
        data_in      <= sync2;
        data_prev    <= primed ? data_in : sync2;
        primed       <= 1'b1;
        sample_valid <= primed;
      end
    end
  end

endmodule

// File: rtl/nios_system_key_pio_in.sv
// Avalon-MM input PIO: debounced key data, IRQ mask and write-1-to-clear edge capture.
module nios_system_key_pio_in
  import nios_system_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned EDGE_TYPE       = EDGE_RISE
) (
  input  logic                    clk,
  input  logic                    reset_n,
  nios_system_key_pio_in_if.slave bus,
  input  logic [WIDTH-1:0]        in_port
);

  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data_prev;
  logic              sample_valid;
  logic [WIDTH-1:0]  irqmask;
  logic [WIDTH-1:0]  edgecap;
  logic [WIDTH-1:0]  edge_set;
  logic [WIDTH-1:0]  edge_clr;
  logic [DATA_W-1:0] rd_next;
  pio_req_t          req;
  logic              unused_wdata;

  nios_system_pio_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .reset_n      (reset_n),
    .in_port      (in_port),
    .data_in      (data_in),
    .data_prev    (data_prev),
    .sample_valid (sample_valid)
  );

  // Only the low WIDTH bits of writedata carry register content.
  assign unused_wdata = ^(bus.writedata >> WIDTH);

  // Bus decode and per-bit set/clear terms for the capture register.
  always_comb begin
    req       = '0;
    req.wr    = bus.chipselect && !bus.write_n;
    req.addr  = bus.address;
    req.wdata = bus.writedata;

    edge_clr = '0;
    if (req.wr && (req.addr == ADDR_EDGECAP)) begin
      edge_clr = req.wdata[WIDTH-1:0];
    end

    edge_set = '0;
    if (sample_valid) begin
      edge_set = WIDTH'(edge_event(EDGE_TYPE, DATA_W'(data_in), DATA_W'(data_prev)));
    end
  end

  // Read mux runs every cycle regardless of chipselect; unmapped words read 0.
  always_comb begin
    rd_next = '0;
    case (bus.address)
      ADDR_DATA:    rd_next = DATA_W'(data_in);
      ADDR_IRQMASK: rd_next = DATA_W'(irqmask);
      ADDR_EDGECAP: rd_next = DATA_W'(edgecap);
      default:      rd_next = '0;
    endcase
  end

  // Set has priority over a simultaneous clear on the same bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask      <= '0;
      edgecap      <= '0;
      bus.readdata <= '0;
    end else begin
      if (req.wr && (req.addr == ADDR_IRQMASK)) begin
        irqmask <= req.wdata[WIDTH-1:0];
      end
      edgecap      <= (edgecap & ~edge_clr) | edge_set;
      bus.readdata <= rd_next;
    end
  end

  assign bus.irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_nios_system_key_pio_in.sv
// Randomized and directed check of the key input PIO (rising and any-edge builds) against a sampled-history model.
module tb_nios_system_key_pio_in;

  localparam int unsigned W  = 18;
  localparam int unsigned DC = 4;

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [2:0]    address    = '0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [W-1:0]  in_port    = '0;

  int n_tests = 0;
  int n_fail  = 0;

  nios_system_key_pio_in_if bus0 ();
  nios_system_key_pio_in_if bus1 ();

  assign bus0.address    = address;
  assign bus0.chipselect = chipselect;
  assign bus0.write_n    = write_n;
  assign bus0.writedata  = writedata;
  assign bus1.address    = address;
  assign bus1.chipselect = chipselect;
  assign bus1.write_n    = write_n;
  assign bus1.writedata  = writedata;

  nios_system_key_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0)) u_dut_rise (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port));

  nios_system_key_pio_in #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) u_dut_any (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port));

  always #5 clk = ~clk;

  // Reference state: debounced value is the input seen two edges before every DC-th edge.
  logic [W-1:0] m_deb = '0, m_prev = '0, m_mask = '0;
  logic [W-1:0] m_ecap0 = '0, m_ecap1 = '0, m_pend0 = '0, m_pend1 = '0;
  logic [31:0]  m_rd0 = '0, m_rd1 = '0;
  bit           m_primed = 1'b0;
  int           m_n = 0;
  logic [W-1:0] hist[$];

  function automatic logic [31:0] reg_view(input logic [2:0] a, input logic [W-1:0] deb,
                                           input logic [W-1:0] mask, input logic [W-1:0] ecap);
    case (a)
      3'd0:    return 32'(deb);
      3'd2:    return 32'(mask);
      3'd3:    return 32'(ecap);
      default: return 32'd0;
    endcase
  endfunction

  initial begin : model
    logic [W-1:0] clr;
    logic [W-1:0] smp;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_deb = '0; m_prev = '0; m_mask = '0;
        m_ecap0 = '0; m_ecap1 = '0; m_pend0 = '0; m_pend1 = '0;
        m_rd0 = '0; m_rd1 = '0; m_primed = 1'b0; m_n = 0;
        hist.delete();
        hist.push_back('0);
        hist.push_back('0);
      end else begin
        m_rd0 = reg_view(address, m_deb, m_mask, m_ecap0);
        m_rd1 = reg_view(address, m_deb, m_mask, m_ecap1);
        clr = (chipselect && !write_n && address == 3'd3) ? writedata[W-1:0] : '0;
        m_ecap0 = (m_ecap0 & ~clr) | m_pend0;
        m_ecap1 = (m_ecap1 & ~clr) | m_pend1;
        m_pend0 = '0;
        m_pend1 = '0;
        if (chipselect && !write_n && address == 3'd2) m_mask = writedata[W-1:0];
        m_n++;
        hist.push_back(in_port);
        while (hist.size() > 3) void'(hist.pop_front());
        if (m_n % int'(DC) == 0) begin
          smp = hist[0];
          if (!m_primed) begin
            m_deb = smp; m_prev = smp; m_primed = 1'b1;
          end else begin
            m_prev = m_deb;
            m_deb  = smp;
            m_pend0 = m_deb & ~m_prev;
            m_pend1 = m_deb ^ m_prev;
          end
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step_and_check(input string tag);
    @(negedge clk);
    check_eq({tag, "_rd_rise"},  bus0.readdata, m_rd0);
    check_eq({tag, "_irq_rise"}, 32'(bus0.irq), 32'(|(m_ecap0 & m_mask)));
    check_eq({tag, "_rd_any"},   bus1.readdata, m_rd1);
    check_eq({tag, "_irq_any"},  32'(bus1.irq), 32'(|(m_ecap1 & m_mask)));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step_and_check("idle");
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step_and_check("wr");
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a);
    chipselect = 1'b1; write_n = 1'b1; address = a;
    step_and_check("rd");
    chipselect = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;

    // Reset with all keys held high: priming must suppress the edge.
    in_port = 18'h3FFFF;
    repeat (3) @(negedge clk);
    check_eq("rst_readdata", bus0.readdata, 32'd0);
    check_eq("rst_irq", 32'(bus0.irq), 32'd0);
    reset_n = 1'b1;
    wait_cycles(10);
    bus_read(3'd0);
    check_eq("s1_data", bus0.readdata, 32'h0003FFFF);
    bus_read(3'd3);
    check_eq("s1_edgecap", bus0.readdata, 32'd0);
    check_eq("s1_irq", 32'(bus0.irq), 32'd0);

    // Rising edge on bit0 with mask set.
    in_port = 18'h3FFFE;
    wait_cycles(12);
    bus_write(3'd3, 32'h3FFFF);
    bus_write(3'd2, 32'h1);
    in_port = 18'h3FFFF;
    found = 1'b0;
    for (int i = 0; i < 7 && !found; i++) begin
      step_and_check("s2_wait");
      if (bus0.irq) found = 1'b1;
    end
    check_eq("s2_irq_within7", 32'(found), 32'd1);
    bus_read(3'd3);
    check_eq("s2_edgecap", bus0.readdata, 32'h1);
    bus_write(3'd3, 32'h1);
    check_eq("s2_irq_cleared", 32'(bus0.irq), 32'd0);
    bus_read(3'd3);
    check_eq("s2_edgecap_cleared", bus0.readdata, 32'd0);

    // Short pulse on bit5 placed between debounce samples.
    in_port = '0;
    wait_cycles(12);
    bus_write(3'd3, 32'h3FFFF);
    for (int i = 0; i < 4 && (m_n % int'(DC) != 3); i++) step_and_check("s3_align");
    in_port = 18'h00020;
    wait_cycles(2);
    in_port = '0;
    wait_cycles(12);
    bus_read(3'd0);
    check_eq("s3_data", bus0.readdata, 32'd0);
    bus_read(3'd3);
    check_eq("s3_edgecap_rise", bus0.readdata, 32'd0);
    check_eq("s3_edgecap_any", bus1.readdata, 32'd0);

    // Clear lands in the same cycle as a bit5 rising event.
    in_port = 18'h00020;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step_and_check("s4_wait");
      if (m_pend0 != '0) found = 1'b1;
    end
    check_eq("s4_event_seen", 32'(found), 32'd1);
    bus_write(3'd3, 32'h20);
    bus_read(3'd3);
    check_eq("s4_set_wins", bus0.readdata, 32'h20);

    // Any-edge build: bit3 falling, then rising.
    in_port = 18'h00008;
    wait_cycles(12);
    bus_write(3'd3, 32'h3FFFF);
    in_port = '0;
    wait_cycles(12);
    bus_read(3'd3);
    check_eq("s5_fall_any", bus1.readdata, 32'h8);
    check_eq("s5_fall_rise", bus0.readdata, 32'h0);
    bus_write(3'd3, 32'h8);
    in_port = 18'h00008;
    wait_cycles(12);
    bus_read(3'd3);
    check_eq("s5_rise_any", bus1.readdata, 32'h8);
    check_eq("s5_rise_rise", bus0.readdata, 32'h8);
    bus_read(3'd5);
    check_eq("s5_addr5", bus1.readdata, 32'd0);

    // Asynchronous reset with pending interrupts.
    in_port = '0;
    wait_cycles(12);
    bus_write(3'd3, 32'h3FFFF);
    bus_write(3'd2, 32'h3);
    in_port = 18'h00003;
    wait_cycles(12);
    bus_read(3'd3);
    check_eq("s6_edgecap", bus0.readdata, 32'h3);
    check_eq("s6_irq", 32'(bus0.irq), 32'd1);
    address = 3'd3;
    #2 reset_n = 1'b0;
    #1;
    check_eq("s6_rst_irq", 32'(bus0.irq), 32'd0);
    check_eq("s6_rst_readdata", bus0.readdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    in_port = '0;
    reset_n = 1'b1;
    bus_read(3'd0);
    check_eq("s6_post_data", bus0.readdata, 32'd0);
    bus_read(3'd2);
    check_eq("s6_post_mask", bus0.readdata, 32'd0);
    bus_read(3'd3);
    check_eq("s6_post_edgecap", bus0.readdata, 32'd0);

    // Random bus traffic and key activity.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      case ($urandom_range(0, 7))
        0: begin chipselect = 1'b1; write_n = 1'b0; address = 3'd2; writedata = $urandom; end
        1: begin chipselect = 1'b1; write_n = 1'b0; address = 3'd3; writedata = $urandom; end
        2: begin chipselect = 1'b0; write_n = 1'b0; address = 3'd3; writedata = 32'hFFFFFFFF; end
        3: begin chipselect = 1'b1; write_n = 1'b0; address = 3'($urandom_range(4, 7)); writedata = $urandom; end
        default: begin
          chipselect = 1'($urandom_range(0, 1)); write_n = 1'b1;
          address = 3'($urandom_range(0, 7)); writedata = $urandom;
        end
      endcase
      step_and_check("rnd");
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_system_key_pio_in.md
# nios_system_key_pio_in

Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO. It samples an external input bus (keys/switches) and synchronizes it into the clk domain. It debounces the bus with a shared sample tick, detects edges per bit, latches them into a write-1-to-clear edge-capture register, and raises a maskable interrupt to the Nios II processor.

## Interface
- WIDTH, 18: number of input bits (1..32).
- DEBOUNCE_CYCLES, 1000: clk cycles between debounce samples (>=1; 1 means sample every cycle).
- EDGE_TYPE, 0: edge that sets capture bits; 0 rising, 1 falling, 2 any.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  3  Avalon word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  asynchronous external inputs.
- readdata  output  32  registered read data; bits above WIDTH always 0.
- irq  output  1  level interrupt, active-high.

## Operation
- Register map, by word address:
  - 0 DATA: read-only; returns the debounced value `data_in`.
  - 2 IRQMASK: read/write; WIDTH bits.
  - 3 EDGECAP: read; a write clears each bit where writedata is 1.
  - 1 and 4..7: read 0; writes ignored.
- Write strobe is `chipselect && !write_n`. Only writedata[WIDTH-1:0] is used.
- Synchronizer:
  - Two flops per bit, `sync1` then `sync2`, both reset to 0.
- Debounce:
  - A free-running counter counts 0..DEBOUNCE_CYCLES-1 and asserts `tick` when it wraps.
  - On `tick`: `data_prev <= data_in` and `data_in <= sync2`.
- Priming:
  - `primed` resets to 0.
  - The first tick after reset loads both `data_in` and `data_prev` from `sync2` and sets `primed`.
  - No edge event is produced on that first tick. This prevents a spurious capture when inputs are already high at reset.
- Edge event (per bit), evaluated only in the cycle after a primed tick:
  - rising: `data_in & ~data_prev`.
  - falling: `~data_in & data_prev`.
  - any: XOR of the two.
- EDGECAP update: `edgecap <= (edgecap & ~clr) | event`.
  - A set and a clear on the same bit in the same cycle leaves the bit set (set wins).
- irq is `|(edgecap & irqmask)`, decoded combinationally from registers. There is no extra flop.
- Reset values: readdata 0, irq 0. The counter, sync1, sync2, data_in, data_prev, primed, irqmask and edgecap are all 0.
- Asserting reset mid-operation clears everything immediately, including pending captures and a partial debounce count. Priming repeats after reset is released.

## Timing
- readdata:
  - Registered every clk from the current address; the address-to-readdata mux is not gated by chipselect.
  - Read latency is 1 cycle: address presented at edge N gives readdata valid after edge N. The master uses 1 fixed read wait state.
- Writes take effect at the edge where the strobe is sampled.
  - A read of the same register in the next cycle returns the new value.
- Input path latency with DEBOUNCE_CYCLES=1:
  - in_port stable before edge 1.
  - sync2 updates at edge 2.
  - data_in updates at edge 3.
  - edgecap bit and irq update at edge 4.
- With larger DEBOUNCE_CYCLES, add up to DEBOUNCE_CYCLES-1 cycles of tick alignment.
- Counter wrap:
  - Tick at count DEBOUNCE_CYCLES-1, then the count returns to 0.
  - The counter is never reset by bus activity.
- A pulse on in_port shorter than the tick spacing may be missed; this is intended debouncing.
- Writing IRQMASK changes irq from the next cycle.

## Structure
- Package `nios_system_pio_pkg` holds:
  - Address constants: ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3.
  - Edge-type constants: EDGE_RISE, EDGE_FALL, EDGE_ANY.
- Sub-module `nios_system_pio_debounce`, parameters WIDTH and DEBOUNCE_CYCLES, contains:
  - The synchronizer, tick counter, primed flag, data_in and data_prev.
  - Outputs: data_in, data_prev and `sample_valid`. `sample_valid` pulses one cycle after each primed tick.
- The top level holds the Avalon decode, irqmask, edgecap, irq and the readdata register.

## Test plan
All scenarios use WIDTH=18, DEBOUNCE_CYCLES=4, EDGE_TYPE=0 unless noted.
1. Reset with in_port=18'h3FFFF.
   - Required: after 10 cycles, DATA reads 0x0003FFFF, EDGECAP reads 0, irq=0 (priming suppresses the edge).
2. IRQMASK=0x00001, then in_port bit0 goes 0->1.
   - Required: within 7 cycles EDGECAP=0x00001 and irq=1.
   - Then write 0x1 to EDGECAP; required: EDGECAP reads 0 and irq=0 the next cycle.
3. in_port bit5 toggles for 2 cycles only, aligned between ticks.
   - Required: DATA and EDGECAP stay 0.
4. Write 0x20 to EDGECAP in the same cycle that a bit5 rising event is applied.
   - Required: EDGECAP reads 0x20 (set wins).
5. EDGE_TYPE=2, bit3 goes 1->0 then 0->1, with EDGECAP cleared between.
   - Required: EDGECAP=0x8 after each transition.
   - Read address 5: required readdata 0.
6. Assert reset_n low while EDGECAP=0x3 and IRQMASK=0x3.
   - Required: irq and readdata fall to 0 immediately.
   - After release, all registers read 0 until a new primed edge occurs.
